// File: rtl/booth_csa_mult.sv
// Iterative radix-4 Booth multiplier; partial products accumulate in carry-save form, one digit per cycle.
// Latency N=XLEN/2+1 cycles from accept to out_valid; result holds in DONE until out_ready, no input queuing.
module booth_csa_mult #(
    parameter int XLEN = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     data0,
    input  logic [XLEN-1:0]     data1,
    input  logic [1:0]          op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*XLEN-1:0]   sum,
    output logic [2*XLEN-1:0]   carry
);
    localparam int N  = XLEN / 2 + 1;
    localparam int PW = 2 * XLEN;
    localparam int EW = XLEN + 2;
    localparam int KW = $clog2(N);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          r_state;
    logic [KW-1:0]   r_k;
    logic [EW-1:0]   r_mp;
    logic            r_prev;
    logic [PW-1:0]   r_mc;
    logic [PW-1:0]   r_sum;
    logic [PW-1:0]   r_carry;
    logic            r_in_ready;
    logic            r_out_valid;

    logic            w_sgn0;
    logic            w_sgn1;
    logic [PW-1:0]   w_mc_ext;
    logic [EW-1:0]   w_mp_ext;
    logic [2:0]      w_bits;
    logic            w_zero;
    logic            w_two;
    logic            w_neg;
    logic [PW-1:0]   w_mag;
    logic [PW-1:0]   w_pp;
    logic [PW-1:0]   w_maj;
    logic [PW-1:0]   w_sum_nxt;
    logic [PW-1:0]   w_carry_nxt;

    // op 11 falls through as unsigned x unsigned
    assign w_sgn0   = (op == 2'b01) || (op == 2'b10);
    assign w_sgn1   = (op == 2'b01);
    assign w_mc_ext = {{(PW-XLEN){w_sgn0 & data0[XLEN-1]}}, data0};
    assign w_mp_ext = {{2{w_sgn1 & data1[XLEN-1]}}, data1};

    // Multiplier is consumed two bits per step from the LSB end; r_prev is bit 2k-1
    assign w_bits = {r_mp[1:0], r_prev};

    always_comb begin
        w_zero = 1'b0;
        w_two  = 1'b0;
        w_neg  = 1'b0;
        case (w_bits)
            3'b000, 3'b111: w_zero = 1'b1;
            3'b001, 3'b010: ;
            3'b011:         w_two  = 1'b1;
            3'b100:         begin w_two = 1'b1; w_neg = 1'b1; end
            default:        w_neg  = 1'b1;
        endcase
    end

    assign w_mag = w_zero ? '0 : (w_two ? (r_mc << 1) : r_mc);
    assign w_pp  = w_neg ? ~w_mag : w_mag;

    // 3:2 compressor; carry LSB is free after the shift, so the two's-complement +1 goes there
    assign w_sum_nxt   = r_sum ^ r_carry ^ w_pp;
    assign w_maj       = (r_sum & r_carry) | (r_sum & w_pp) | (r_carry & w_pp);
    assign w_carry_nxt = {w_maj[PW-2:0], w_neg};

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_mp        <= '0;
            r_prev      <= 1'b0;
            r_mc        <= '0;
            r_sum       <= '0;
            r_carry     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_state    <= BUSY;
                        r_k        <= '0;
                        r_mp       <= w_mp_ext;
                        r_prev     <= 1'b0;
                        r_mc       <= w_mc_ext;
                        r_sum      <= '0;
                        r_carry    <= '0;
                        r_in_ready <= 1'b0;
                    end
                end
                BUSY: begin
                    r_sum   <= w_sum_nxt;
                    r_carry <= w_carry_nxt;
                    r_mp    <= {2'b00, r_mp[EW-1:2]};
                    r_prev  <= r_mp[1];
                    r_mc    <= r_mc << 2;
                    r_k     <= r_k + 1'b1;
                    if (r_k == KW'(N-1)) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign carry     = r_carry;

endmodule

// File: tb/tb_booth_csa_mult.sv
// Directed-vector bench for booth_csa_mult at XLEN=32: products, latency, backpressure, reset, throughput.
module tb_booth_csa_mult;
    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data0;
    logic [31:0] data1;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic [63:0] carry;

    int errors = 0;
    int checks = 0;

    booth_csa_mult #(.XLEN(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data0     (data0),
        .data1     (data1),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Resolves the redundant pair the way the downstream adder does
    function automatic logic [63:0] resolved();
        return sum + carry;
    endfunction

    // Stimulus only: issues one op from IDLE and waits (bounded) for out_valid; lat=-1 on timeout
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output int lat);
        op = o; data0 = a; data1 = b; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        res = resolved();
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (sum !== 64'd0)      begin errors++; $display("FAIL reset_sum got=%h want=0", sum); end
        checks++; if (carry !== 64'd0)    begin errors++; $display("FAIL reset_carry got=%h want=0", carry); end
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_unsigned_max();
        logic [63:0] r; int lat;
        do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat);
        checks++; if (lat !== 17) begin errors++; $display("FAIL umax_latency got=%0d want=17", lat); end
        checks++; if (r !== 64'hFFFFFFFE00000001) begin errors++; $display("FAIL umax_product got=%h want=FFFFFFFE00000001", r); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL umax_in_ready_done got=%b want=0", in_ready); end
        consume();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL umax_release got=%b%b want=10", in_ready, out_valid); end
    endtask

    task automatic test_signed();
        logic [63:0] vec_res [4];
        logic [1:0]  vec_op  [4];
        logic [31:0] vec_a   [4];
        logic [31:0] vec_b   [4];
        logic [63:0] r; int lat;
        vec_op[0] = 2'b01; vec_a[0] = 32'h80000000; vec_b[0] = 32'h80000000; vec_res[0] = 64'h4000000000000000;
        vec_op[1] = 2'b01; vec_a[1] = 32'hFFFFFFFD; vec_b[1] = 32'd7;        vec_res[1] = 64'hFFFFFFFFFFFFFFEB;
        vec_op[2] = 2'b01; vec_a[2] = 32'd1;        vec_b[2] = 32'hFFFFFFFF; vec_res[2] = 64'hFFFFFFFFFFFFFFFF;
        vec_op[3] = 2'b01; vec_a[3] = 32'h7FFFFFFF; vec_b[3] = 32'h80000000; vec_res[3] = 64'hC000000080000000;
        for (int i = 0; i < 4; i++) begin
            do_op(vec_op[i], vec_a[i], vec_b[i], r, lat);
            checks++; if (lat !== 17) begin errors++; $display("FAIL signed_latency[%0d] got=%0d want=17", i, lat); end
            checks++; if (r !== vec_res[i]) begin errors++; $display("FAIL signed_product[%0d] got=%h want=%h", i, r, vec_res[i]); end
            consume();
        end
    endtask

    task automatic test_signedness();
        logic [63:0] vec_res [6];
        logic [1:0]  vec_op  [6];
        logic [31:0] vec_a   [6];
        logic [31:0] vec_b   [6];
        logic [63:0] r; int lat;
        vec_op[0] = 2'b00; vec_a[0] = 32'hFFFFFFFD; vec_b[0] = 32'd7;        vec_res[0] = 64'h00000006FFFFFFEB;
        vec_op[1] = 2'b10; vec_a[1] = 32'hFFFFFFFF; vec_b[1] = 32'hFFFFFFFF; vec_res[1] = 64'hFFFFFFFF00000001;
        vec_op[2] = 2'b11; vec_a[2] = 32'hFFFFFFFD; vec_b[2] = 32'd7;        vec_res[2] = 64'h00000006FFFFFFEB;
        vec_op[3] = 2'b11; vec_a[3] = 32'hFFFFFFFF; vec_b[3] = 32'hFFFFFFFF; vec_res[3] = 64'hFFFFFFFE00000001;
        vec_op[4] = 2'b10; vec_a[4] = 32'hFFFFFFFF; vec_b[4] = 32'd2;        vec_res[4] = 64'hFFFFFFFFFFFFFFFE;
        vec_op[5] = 2'b00; vec_a[5] = 32'd0;        vec_b[5] = 32'hFFFFFFFF; vec_res[5] = 64'd0;
        for (int i = 0; i < 6; i++) begin
            do_op(vec_op[i], vec_a[i], vec_b[i], r, lat);
            checks++; if (r !== vec_res[i]) begin errors++; $display("FAIL sgn_product[%0d] got=%h want=%h", i, r, vec_res[i]); end
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] r; int lat;
        do_op(2'b00, 32'd1000, 32'd3000, r, lat);
        checks++; if (r !== 64'd3000000) begin errors++; $display("FAIL bp_product got=%h want=%h", r, 64'd3000000); end
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            data0 = 32'h12345678 + i; data1 = 32'h9ABCDEF0; op = 2'b01;
            @(posedge clock); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d] got=%b want=1", i, out_valid); end
            checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_in_ready[%0d] got=%b want=0", i, in_ready); end
            checks++; if (resolved() !== 64'd3000000) begin errors++; $display("FAIL bp_hold[%0d] got=%h want=%h", i, resolved(), 64'd3000000); end
        end
        in_valid = 1'b0;
        consume();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%b%b want=10", in_ready, out_valid); end
        repeat (3) @(posedge clock);
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_capture got=%b%b want=10", in_ready, out_valid); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] r; int lat; int seen;
        op = 2'b01; data0 = 32'hFFFFFFFF; data1 = 32'h7FFFFFFF; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rmid_state got=%b%b want=10", in_ready, out_valid); end
        checks++; if (sum !== 64'd0 || carry !== 64'd0) begin errors++; $display("FAIL rmid_clear got=%h/%h want=0/0", sum, carry); end
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clock); #1;
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rmid_no_output got=%0d want=0", seen); end
        do_op(2'b01, 32'd5, 32'hFFFFFFFA, r, lat);
        checks++; if (lat !== 17) begin errors++; $display("FAIL rmid_latency got=%0d want=17", lat); end
        checks++; if (r !== 64'hFFFFFFFFFFFFFFE2) begin errors++; $display("FAIL rmid_product got=%h want=FFFFFFFFFFFFFFE2", r); end
        consume();
    endtask

    task automatic test_back_to_back();
        int t[$];
        int cyc;
        op = 2'b00; data0 = 32'd3; data1 = 32'd5;
        in_valid = 1'b1; out_ready = 1'b1;
        for (cyc = 0; cyc < 60; cyc++) begin
            @(posedge clock); #1;
            if (out_valid) begin
                t.push_back(cyc);
                checks++; if (resolved() !== 64'd15) begin errors++; $display("FAIL b2b_product cyc=%0d got=%h want=f", cyc, resolved()); end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (t.size() < 2) begin
            errors++; $display("FAIL b2b_count got=%0d want>=2", t.size());
        end else if (t[1] - t[0] !== 19) begin
            errors++; $display("FAIL b2b_period got=%0d want=19", t[1] - t[0]);
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        data0 = '0; data1 = '0; op = 2'b00;
        test_reset();
        test_unsigned_max();
        test_signed();
        test_signedness();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/booth_csa_mult.md
Name: booth_csa_mult

Overview:
- Iterative radix-4 Booth multiplier that accumulates partial products in carry-save form. Sits directly upstream of the final carry-propagate adder `add`.
- Emits a redundant sum/carry pair whose modular sum is the full 2*XLEN-bit product. The downstream `add` (op=0, data0=sum, data1=carry, instantiated at width 2*XLEN) resolves it to binary.
- Trades area for latency: one Booth digit is retired per cycle.

Parameters:
- XLEN, 32, operand width; must be even and >= 4.
- N (localparam), XLEN/2+1, number of Booth steps per operation.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  block can accept an operation.
- data0  in  XLEN  multiplicand.
- data1  in  XLEN  multiplier.
- op  in  2  signedness: 00 unsigned×unsigned, 01 signed×signed, 10 signed(data0)×unsigned(data1), 11 treated as 00.
- out_valid  out  1  sum/carry hold a finished result.
- out_ready  in  1  downstream consumes the result.
- sum  out  2*XLEN  carry-save sum vector.
- carry  out  2*XLEN  carry-save carry vector.

Behaviour:
- Reset: when reset==0 at a rising edge:
  - state=IDLE; sum=0, carry=0, step counter=0, captured operands=0.
  - out_valid=0, in_ready=1 from the next cycle.
  - Reset has priority over every other event, including mid-BUSY and in DONE; an in-flight operation is discarded with no output.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE -> BUSY on an edge with in_valid=1.
  - Capture data0 and data1, each extended to XLEN+2 bits: sign-extended if that operand is signed per op, else zero-extended.
  - Clear sum, carry and step counter k to 0.
  - in_valid while not IDLE is ignored; no queuing.
- BUSY, each edge:
  - Booth digit d_k ∈ {-2,-1,0,1,2} from extended multiplier bits [2k+1:2k-1], with bit -1 = 0.
  - Partial product PP_k = d_k × extended multiplicand × 4^k, taken mod 2^(2XLEN).
  - Fold PP_k into (sum, carry) with a 3:2 compressor. Negative digits use invert-plus-one; the +1 must be injected so the invariant holds exactly.
  - Invariant after step k: (sum+carry) mod 2^(2XLEN) == Σ_{j<=k} PP_j mod 2^(2XLEN).
  - Increment k. When k reaches N-1 and that step completes, go to DONE.
- Latency: exactly N cycles from the accepting edge to out_valid=1 (17 for XLEN=32).
- DONE:
  - sum and carry hold stable until an edge with out_ready=1, then IDLE.
  - The next operation may be accepted one cycle later (in_ready rises after leaving DONE).
  - No combinational path from in_valid to in_ready or from out_ready to out_valid.
- Results:
  - (sum+carry) mod 2^(2XLEN) equals the exact product for the selected signedness, truncated to 2*XLEN bits.
  - Individual sum/carry bit patterns are implementation-defined; only their modular sum is specified.
- Overflow: carries beyond bit 2*XLEN-1 are dropped in every step. No overflow flag.
- Throughput: one operation per N+2 cycles when out_ready is held at 1.

Test Plan (XLEN=32; check sum+carry via downstream add, width 64):
- Unsigned max: op=00, data0=data1=0xFFFFFFFF -> out_valid exactly 17 cycles after accept; sum+carry = 0xFFFFFFFE00000001.
- Signed min: op=01, data0=data1=0x80000000 -> 0x4000000000000000. Also op=01, data0=0xFFFFFFFD, data1=7 -> 0xFFFFFFFFFFFFFFEB.
- Signedness contrast:
  - op=00, data0=0xFFFFFFFD, data1=7 -> 0x00000006FFFFFFEB.
  - op=10, data0=data1=0xFFFFFFFF -> 0xFFFFFFFF00000001.
  - op=11 gives the same result as op=00.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while toggling in_valid with new operands -> sum/carry/out_valid stable, in_ready=0, new operands not captured. Raise out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-operation: drop reset to 0 for one edge at step k=8 -> next cycle state IDLE, sum=carry=0, out_valid=0, in_ready=1, no result produced. A following op=01, 5×-6 (data1=0xFFFFFFFA) -> 0xFFFFFFFFFFFFFFE2.
- Random regression: 10k operations with random op and operands and random out_ready stalls, seeded by SEED -> every result matches the reference product; latency is always 17 cycles.
